muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS five-stage pipeline. Executes MULT, MULTU, DIV and DIVU using one shared WIDTH-bit add/subtract step per cycle, and owns the architectural HI/LO registers.
- Sits beside the EX-stage ALU. The hazard unit stalls the pipeline on `busy`. HI/LO feed MFHI/MFLO, and MTHI/MTLO write HI/LO directly.

Parameters:
- WIDTH, 32: operand and HI/LO width; iteration count equals WIDTH.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch the operation given by op.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- data1  input  WIDTH  rs operand: multiplicand or dividend.
- data2  input  WIDTH  rt operand: multiplier or divisor.
- cancel  input  1  abort the in-flight operation (pipeline flush).
- hilo_we  input  1  MTHI/MTLO write enable.
- hilo_sel  input  1  0 = write LO, 1 = write HI.
- hilo_wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight; the pipeline stalls while high.
- done  output  1  one-cycle pulse: HI/LO just updated by an operation.
- div_by_zero  output  1  pulses together with done for DIV/DIVU with data2 == 0.
- hi  output  WIDTH  HI register (product high / remainder).
- lo  output  WIDTH  LO register (product low / quotient).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. While reset is high at an edge: state=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0, counter=0. This applies equally mid-operation; no partial result is written.
- State machine states: IDLE, PREP, RUN, FIX.
- IDLE:
  - With start=1, latch op, data1, data2 and go to PREP.
  - Otherwise, with hilo_we=1, write hilo_wdata into the register chosen by hilo_sel.
  - If start and hilo_we are both 1, start wins and the write is dropped.
- PREP (1 cycle):
  - For signed ops, take the magnitudes of both operands; record neg_q = sign1^sign2 and neg_r = sign1.
  - Unsigned ops pass operands through unchanged.
  - Clear the 2*WIDTH working register and set counter=0. Go to RUN.
- RUN (WIDTH cycles): one step per cycle, then counter++. The last step (counter==WIDTH-1) goes to FIX.
  - Multiply step (shift-add): if work[0], add the multiplicand to work[2W-1:W] with carry-out; shift the WIDTH+1-bit sum:low pair right by 1.
  - Divide step (restoring): shift {rem,quo} left by 1; trial = rem - divisor. If there is no borrow, rem=trial and quo[0]=1.
- FIX (1 cycle):
  - Signed multiply with neg_q: two's-complement negate the 2W-bit product.
  - Signed divide: negate the quotient if neg_q; negate the remainder if neg_r.
  - Write HI/LO, set done=1 (and div_by_zero when it applies) for the next cycle only, and go to IDLE.
- Latency: with start sampled at edge E0, HI/LO and done appear after edge E(WIDTH+2), i.e. E34 for WIDTH=32. busy=1 from after E0 until after E34; busy is a combinational decode of state != IDLE. The cycle where done=1 is IDLE, so a back-to-back start is accepted there.
- Divide by zero: same latency; final hi = data1 as latched and lo = all ones, regardless of sign; div_by_zero=1 with done.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag; two's-complement wrap.
- Ignored while busy: start, and hilo_we (the pipeline guarantees a stall in that case).
- cancel=1 while busy: return to IDLE at the next edge, leave HI/LO unchanged, no done. In IDLE, cancel has no effect. If reset and cancel are both high, reset dominates.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E34: hi=0xFFFFFFFE, lo=0x00000001, done one cycle; busy high exactly 34 cycles.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Second start issued in the done cycle; result at its own E34.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 with done. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- In IDLE, MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi/lo updated at the next edge. hilo_we while busy -> no change. start+hilo_we together -> write dropped, op runs.
- Start MULTU 5 x 6 with hi/lo=0xAA/0xBB; cancel at E10 -> busy=0 after E11, hi/lo stay 0xAA/0xBB, no done.
- Reset asserted at E20 of a DIVU -> after E21: busy=0, hi=lo=0, done=0. The next start completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restoring-divide step per cycle; result lands WIDTH+2 cycles after start.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             cancel,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] work;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;

  logic               is_div;
  logic               is_signed;
  logic               last_step;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   diff;
  logic               no_borrow;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dbz;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign last_step = (cnt == LAST_CNT);
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply: add multiplicand into the upper half, keep the carry, shift right.
  always_comb begin
    msum     = {1'b0, work[2*WIDTH-1:WIDTH]} +
               (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next = {msum, work[WIDTH-1:1]};
  end

  // Divide: the bit shifted out of rem is kept in the trial subtraction.
  always_comb begin
    diff      = {1'b0, work[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
    no_borrow = ~diff[WIDTH+1];
    div_next  = {(no_borrow ? diff[WIDTH-1:0] : work[2*WIDTH-2:WIDTH-1]),
                 work[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    prod    = (is_signed && neg_q) ? -work : work;
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];
    res_dbz = 1'b0;
    if (is_div) begin
      if (b_q == '0) begin
        res_hi  = a_q;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_lo = (is_signed && neg_q) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        res_hi = (is_signed && neg_r) ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: state_nxt = cancel ? IDLE : RUN;
      RUN: begin
        if (cancel)         state_nxt = IDLE;
        else if (last_step) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      work        <= '0;
      opnd        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= data1;
            b_q  <= data2;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
        end
        PREP: begin
          neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= is_signed & a_q[WIDTH-1];
          cnt   <= '0;
          if (is_div) begin
            opnd <= mag_b;
            work <= {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd <= mag_a;
            work <= {{WIDTH{1'b0}}, mag_b};
          end
        end
        RUN: begin
          if (!cancel) begin
            work <= is_div ? div_next : mul_next;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            hi          <= res_hi;
            lo          <= res_lo;
            done        <= 1'b1;
            div_by_zero <= res_dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
